// File: rtl/vga_timing_gen.sv
// Raster timing generator and pixel gate: emits pixel addresses, gates returned pixel data, and produces aligned sync/DE/start strobes.
// Latency: sync, DE, start strobes and pixel_out appear PIPE_LAT+1 cycles after the matching column_addr/row_addr.
// Backpressure: none; free-running at the pixel clock, and frame_sync re-phases the counters.
//
// Ports:
//   clk, rst (synchronous, active-low)      pixel clock and reset
//   frame_sync                              genlock pulse; loads FS_HLOAD/FS_VLOAD and applies a pending commit
//   column_addr, row_addr, addr_valid       raw raster position issued to the pixel source
//   pixel_in                                pixel data returned PIPE_LAT cycles after its address
//   pixel_out, de_out, hsync_out,           gated pixel data and timing outputs, all aligned to one another
//   vsync_out, frame_start, line_start
//   cfg_we, cfg_addr, cfg_wdata             shadow timing register writes (0..7 timing fields, 8 polarity)
//   cfg_commit, cfg_pending                 request and status of a shadow-to-active copy at the next frame boundary

module vga_timing_gen #(
   parameter int HBITS    = 12,
   parameter int VBITS    = 11,
   parameter int BPC      = 8,
   parameter int NCH      = 3,
   parameter int PIPE_LAT = 1,
   parameter int H_VIS    = 800,
   parameter int H_FP     = 40,
   parameter int H_SP     = 128,
   parameter int H_BP     = 88,
   parameter int V_VIS    = 600,
   parameter int V_FP     = 1,
   parameter int V_SP     = 4,
   parameter int V_BP     = 23,
   parameter bit HS_INV   = 1'b0,
   parameter bit VS_INV   = 1'b0,
   parameter int FS_HLOAD = H_VIS,
   parameter int FS_VLOAD = V_VIS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_sync,
   output logic [HBITS-1:0]   column_addr,
   output logic [VBITS-1:0]   row_addr,
   output logic               addr_valid,
   input  logic [NCH*BPC-1:0] pixel_in,
   output logic [NCH*BPC-1:0] pixel_out,
   output logic               de_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               frame_start,
   output logic               line_start,
   input  logic               cfg_we,
   input  logic [3:0]         cfg_addr,
   input  logic [15:0]        cfg_wdata,
   input  logic               cfg_commit,
   output logic               cfg_pending
);

   typedef struct packed {
      logic [HBITS-1:0] hvis;
      logic [HBITS-1:0] hfp;
      logic [HBITS-1:0] hsp;
      logic [HBITS-1:0] hbp;
      logic [VBITS-1:0] vvis;
      logic [VBITS-1:0] vfp;
      logic [VBITS-1:0] vsp;
      logic [VBITS-1:0] vbp;
      logic             vs_inv;
      logic             hs_inv;
   } timing_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic sof;
      logic sol;
   } ctl_t;

   localparam timing_t TIM_DEF = {HBITS'(H_VIS), HBITS'(H_FP), HBITS'(H_SP), HBITS'(H_BP),
                                  VBITS'(V_VIS), VBITS'(V_FP), VBITS'(V_SP), VBITS'(V_BP),
                                  VS_INV, HS_INV};
   localparam logic [HBITS:0] H_ONE = (HBITS+1)'(1);
   localparam logic [VBITS:0] V_ONE = (VBITS+1)'(1);

   timing_t          act;
   timing_t          shd;
   logic [HBITS-1:0] hcnt;
   logic [VBITS-1:0] vcnt;

   // One extra bit so the running sums of the porch/sync fields do not wrap.
   logic [HBITS:0]   h_sync_start;
   logic [HBITS:0]   h_sync_end;
   logic [HBITS:0]   h_total;
   logic [VBITS:0]   v_sync_start;
   logic [VBITS:0]   v_sync_end;
   logic [VBITS:0]   v_total;
   logic             h_wrap;
   logic             v_wrap;
   logic             frame_end;
   logic             apply;
   ctl_t             raw;
   ctl_t             dly;
   logic             cfg_unused;

   // Only the low HBITS/VBITS of the write data are meaningful.
   assign cfg_unused = ^cfg_wdata;

   always_comb begin
      h_sync_start = {1'b0, act.hvis} + {1'b0, act.hfp};
      h_sync_end   = h_sync_start + {1'b0, act.hsp};
      h_total      = h_sync_end + {1'b0, act.hbp};
      v_sync_start = {1'b0, act.vvis} + {1'b0, act.vfp};
      v_sync_end   = v_sync_start + {1'b0, act.vsp};
      v_total      = v_sync_end + {1'b0, act.vbp};
   end

   assign h_wrap    = ({1'b0, hcnt} == (h_total - H_ONE));
   assign v_wrap    = ({1'b0, vcnt} == (v_total - V_ONE));
   assign frame_end = h_wrap & v_wrap;
   // Shadow is copied only at a frame boundary or on genlock, never mid-frame.
   assign apply     = cfg_pending & (frame_sync | frame_end);

   assign column_addr = hcnt;
   assign row_addr    = vcnt;
   assign addr_valid  = (hcnt < act.hvis) && (vcnt < act.vvis);

   // A zero-width sync field gives start == end, so the window is empty.
   assign raw.hs  = ({1'b0, hcnt} >= h_sync_start) && ({1'b0, hcnt} < h_sync_end);
   assign raw.vs  = ({1'b0, vcnt} >= v_sync_start) && ({1'b0, vcnt} < v_sync_end);
   assign raw.de  = addr_valid;
   assign raw.sof = addr_valid && (hcnt == '0) && (vcnt == '0);
   assign raw.sol = addr_valid && (hcnt == '0);

   // Raster counters, commit handshake and shadow/active timing registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hcnt        <= '0;
         vcnt        <= '0;
         act         <= TIM_DEF;
         shd         <= TIM_DEF;
         cfg_pending <= 1'b0;
      end else begin
         if (frame_sync) begin
            hcnt <= HBITS'(FS_HLOAD);
            vcnt <= VBITS'(FS_VLOAD);
         end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? '0 : vcnt + VBITS'(1);
         end else begin
            hcnt <= hcnt + HBITS'(1);
         end

         if (apply) begin
            act <= shd;
         end
         // A commit landing on the apply cycle stays pending for the next boundary.
         cfg_pending <= cfg_commit | (cfg_pending & ~apply);

         // A write on the apply cycle lands in shadow after the old value is copied.
         if (cfg_we) begin
            case (cfg_addr)
               4'd0:    shd.hvis <= cfg_wdata[HBITS-1:0];
               4'd1:    shd.hfp  <= cfg_wdata[HBITS-1:0];
               4'd2:    shd.hsp  <= cfg_wdata[HBITS-1:0];
               4'd3:    shd.hbp  <= cfg_wdata[HBITS-1:0];
               4'd4:    shd.vvis <= cfg_wdata[VBITS-1:0];
               4'd5:    shd.vfp  <= cfg_wdata[VBITS-1:0];
               4'd6:    shd.vsp  <= cfg_wdata[VBITS-1:0];
               4'd7:    shd.vbp  <= cfg_wdata[VBITS-1:0];
               4'd8: begin
                  shd.hs_inv <= cfg_wdata[0];
                  shd.vs_inv <= cfg_wdata[1];
               end
               default: ;
            endcase
         end
      end
   end

   // Delay line matching the pixel source latency.
   generate
      if (PIPE_LAT == 0) begin : g_no_dly
         assign dly = raw;
      end else begin : g_dly
         ctl_t pipe [PIPE_LAT];
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= raw;
               for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign dly = pipe[PIPE_LAT-1];
      end
   endgenerate

   // Output stage; pixel_in is sampled on the cycle its delayed DE leaves the line.
   // Polarity uses the live active value, so a commit can flip it mid-pipeline.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pixel_out   <= '0;
         de_out      <= 1'b0;
         hsync_out   <= HS_INV;
         vsync_out   <= VS_INV;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         pixel_out   <= dly.de ? pixel_in : '0;
         de_out      <= dly.de;
         hsync_out   <= dly.hs ^ act.hs_inv;
         vsync_out   <= dly.vs ^ act.vs_inv;
         frame_start <= dly.sof;
         line_start  <= dly.sol;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   // Reduced raster for a short run: 16 x 8 total, 8 x 4 visible.
   // hsync at hcnt 10..12, vsync at vcnt 5..6.
   localparam int HB = 12;
   localparam int VB = 11;
   localparam int PW = 24;
   localparam logic [PW-1:0] PIX_A = 24'hA5C3E1;

   logic          clk;
   logic          rst;
   logic          frame_sync;
   logic          cfg_we;
   logic [3:0]    cfg_addr;
   logic [15:0]   cfg_wdata;
   logic          cfg_commit;

   logic [HB-1:0] col_a;
   logic [VB-1:0] row_a;
   logic          av_a;
   logic [PW-1:0] pin_a;
   logic [PW-1:0] pout_a;
   logic          de_a, hs_a, vs_a, fs_a, ls_a, pend_a;

   logic [HB-1:0] col_b;
   logic [VB-1:0] row_b;
   logic          av_b;
   logic [PW-1:0] pin_b;
   logic [PW-1:0] pout_b;
   logic          de_b, hs_b, vs_b, fs_b, ls_b, pend_b;
   logic          zero_b;
   logic [3:0]    zaddr_b;
   logic [15:0]   zdata_b;
   logic [PW-1:0] q1, q2, q3;

   int tests = 0;
   int fails = 0;
   int c = 0;
   bit b_on = 0;
   int n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0, n_ls = 0;

   vga_timing_gen #(
      .PIPE_LAT(1), .H_VIS(8), .H_FP(2), .H_SP(3), .H_BP(3),
      .V_VIS(4), .V_FP(1), .V_SP(2), .V_BP(1)
   ) dut_a (
      .clk(clk), .rst(rst), .frame_sync(frame_sync),
      .column_addr(col_a), .row_addr(row_a), .addr_valid(av_a),
      .pixel_in(pin_a), .pixel_out(pout_a), .de_out(de_a),
      .hsync_out(hs_a), .vsync_out(vs_a), .frame_start(fs_a), .line_start(ls_a),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_commit(cfg_commit), .cfg_pending(pend_a)
   );

   vga_timing_gen #(
      .PIPE_LAT(3), .H_VIS(8), .H_FP(2), .H_SP(3), .H_BP(3),
      .V_VIS(4), .V_FP(1), .V_SP(2), .V_BP(1)
   ) dut_b (
      .clk(clk), .rst(rst), .frame_sync(zero_b),
      .column_addr(col_b), .row_addr(row_b), .addr_valid(av_b),
      .pixel_in(pin_b), .pixel_out(pout_b), .de_out(de_b),
      .hsync_out(hs_b), .vsync_out(vs_b), .frame_start(fs_b), .line_start(ls_b),
      .cfg_we(zero_b), .cfg_addr(zaddr_b), .cfg_wdata(zdata_b),
      .cfg_commit(zero_b), .cfg_pending(pend_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pixel source for dut_b: returns {row,col} three cycles after the address.
   always @(posedge clk) begin
      q1 <= {1'b0, row_b, col_b};
      q2 <= q1;
      q3 <= q2;
   end
   assign pin_b = q3;
   assign pin_a = PIX_A;

   typedef struct {
      int cyc;
      int col;
      int row;
      int av;
      int de;
      int hs;
      int vs;
      int fs;
      int ls;
   } vec_t;

   vec_t vt [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit raw_de(input int k);
      return ((k % 16) < 8) && (((k / 16) % 8) < 4);
   endfunction

   task automatic check_b();
      logic [31:0] e_pix;
      bit          e_de;
      int          k;
      k     = c - 4;
      e_de  = (c >= 4) && raw_de(k);
      e_pix = e_de ? {9'd0, 11'((k / 16) % 8), 12'(k % 16)} : 32'd0;
      chk("b_de", 32'(de_b), 32'(e_de));
      chk("b_pix", 32'(pout_b), e_pix);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      c++;
      if (b_on && c < 140) check_b();
      if (c >= 2 && c < 130) begin
         n_de += int'(de_a);
         n_hs += int'(hs_a);
         n_vs += int'(vs_a);
         n_fs += int'(fs_a);
         n_ls += int'(ls_a);
      end
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      step();
      cfg_we    = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
   endtask

   task automatic chk_pos(input string name, input int col, input int row);
      chk({name, "_col"}, 32'(col_a), 32'(col));
      chk({name, "_row"}, 32'(row_a), 32'(row));
   endtask

   initial begin
      //        cyc  col row av de hs vs fs ls
      vt[0]  = '{  0,  0, 0, 1, 0, 0, 0, 0, 0};
      vt[1]  = '{  1,  1, 0, 1, 0, 0, 0, 0, 0};
      vt[2]  = '{  2,  2, 0, 1, 1, 0, 0, 1, 1};
      vt[3]  = '{  3,  3, 0, 1, 1, 0, 0, 0, 0};
      vt[4]  = '{  9,  9, 0, 0, 1, 0, 0, 0, 0};
      vt[5]  = '{ 10, 10, 0, 0, 0, 0, 0, 0, 0};
      vt[6]  = '{ 12, 12, 0, 0, 0, 1, 0, 0, 0};
      vt[7]  = '{ 14, 14, 0, 0, 0, 1, 0, 0, 0};
      vt[8]  = '{ 15, 15, 0, 0, 0, 0, 0, 0, 0};
      vt[9]  = '{ 16,  0, 1, 1, 0, 0, 0, 0, 0};
      vt[10] = '{ 18,  2, 1, 1, 1, 0, 0, 0, 1};
      vt[11] = '{ 64,  0, 4, 0, 0, 0, 0, 0, 0};
      vt[12] = '{ 66,  2, 4, 0, 0, 0, 0, 0, 0};
      vt[13] = '{ 82,  2, 5, 0, 0, 0, 1, 0, 0};
      vt[14] = '{ 94, 14, 5, 0, 0, 1, 1, 0, 0};
      vt[15] = '{113,  1, 7, 0, 0, 0, 1, 0, 0};
      vt[16] = '{114,  2, 7, 0, 0, 0, 0, 0, 0};
      vt[17] = '{127, 15, 7, 0, 0, 0, 0, 0, 0};
      vt[18] = '{128,  0, 0, 1, 0, 0, 0, 0, 0};
      vt[19] = '{130,  2, 0, 1, 1, 0, 0, 1, 1};

      rst        = 1'b0;
      frame_sync = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = 4'd0;
      cfg_wdata  = 16'd0;
      cfg_commit = 1'b0;
      zero_b     = 1'b0;
      zaddr_b    = 4'd0;
      zdata_b    = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      rst  = 1'b1;
      c    = 0;
      b_on = 1'b1;

      chk("rst_pending", 32'(pend_a), 32'd0);
      chk("rst_b_pix", 32'(pout_b), 32'd0);

      // Free-running default raster, dut_b pixel path checked every step.
      for (int i = 0; i < 20; i++) begin
         while (c < vt[i].cyc) step();
         chk("vec_col", 32'(col_a), 32'(vt[i].col));
         chk("vec_row", 32'(row_a), 32'(vt[i].row));
         chk("vec_av", 32'(av_a), 32'(vt[i].av));
         chk("vec_de", 32'(de_a), 32'(vt[i].de));
         chk("vec_hs", 32'(hs_a), 32'(vt[i].hs));
         chk("vec_vs", 32'(vs_a), 32'(vt[i].vs));
         chk("vec_fs", 32'(fs_a), 32'(vt[i].fs));
         chk("vec_ls", 32'(ls_a), 32'(vt[i].ls));
         chk("vec_pix", 32'(pout_a), vt[i].de != 0 ? 32'(PIX_A) : 32'd0);
      end
      chk("frame_de_cycles", 32'(n_de), 32'd32);
      chk("frame_hs_cycles", 32'(n_hs), 32'd24);
      chk("frame_vs_cycles", 32'(n_vs), 32'd32);
      chk("frame_fs_count", 32'(n_fs), 32'd1);
      chk("frame_ls_count", 32'(n_ls), 32'd4);

      // Mid-frame reprogram to 10x5 with inverted syncs; writes to 9 and 12 must be ignored.
      wr(4'd0, 16'd4); wr(4'd1, 16'd1); wr(4'd2, 16'd2); wr(4'd3, 16'd3);
      wr(4'd4, 16'd2); wr(4'd5, 16'd1); wr(4'd6, 16'd1); wr(4'd7, 16'd1);
      wr(4'd8, 16'd3); wr(4'd9, 16'd0); wr(4'd12, 16'd0);
      commit();
      chk("commit_pending", 32'(pend_a), 32'd1);
      chk_pos("commit_midframe", 14, 0);
      adv(113);
      chk_pos("old_frame_end", 15, 7);
      chk("pending_until_wrap", 32'(pend_a), 32'd1);
      step();
      chk_pos("new_frame_start", 0, 0);
      chk("pending_cleared", 32'(pend_a), 32'd0);
      adv(2);
      chk("inv_hs_idle", 32'(hs_a), 32'd1);
      chk("inv_vs_idle", 32'(vs_a), 32'd1);
      chk("new_de_first", 32'(de_a), 32'd1);
      adv(3);
      chk("new_de_last", 32'(de_a), 32'd1);
      adv(1);
      chk("new_de_off", 32'(de_a), 32'd0);
      adv(1);
      chk("inv_hs_active", 32'(hs_a), 32'd0);
      adv(2);
      chk("inv_hs_release", 32'(hs_a), 32'd1);
      chk_pos("new_line_end", 9, 0);
      adv(1);
      chk_pos("new_line_wrap", 0, 1);
      adv(22);
      chk("inv_vs_active", 32'(vs_a), 32'd0);
      adv(17);
      chk_pos("new_frame_end", 9, 4);
      adv(1);
      chk_pos("new_period", 0, 0);

      // Restore defaults in shadow, commit, then genlock mid-frame.
      wr(4'd0, 16'd8); wr(4'd1, 16'd2); wr(4'd2, 16'd3); wr(4'd3, 16'd3);
      wr(4'd4, 16'd4); wr(4'd5, 16'd1); wr(4'd6, 16'd2); wr(4'd7, 16'd1);
      wr(4'd8, 16'd0);
      commit();
      chk_pos("fs_before", 0, 1);
      chk("fs_pending", 32'(pend_a), 32'd1);
      adv(3);
      frame_sync = 1'b1;
      step();
      frame_sync = 1'b0;
      chk_pos("fs_load", 8, 4);
      chk("fs_applied", 32'(pend_a), 32'd0);
      adv(8);
      chk_pos("fs_default_timing", 0, 5);
      chk("fs_hs_polarity", 32'(hs_a), 32'd0);

      // Commit coinciding with the frame-end wrap while one is already pending.
      wr(4'd8, 16'd1);
      commit();
      adv(45);
      chk_pos("wrap_commit_at", 15, 7);
      chk("wrap_pending_before", 32'(pend_a), 32'd1);
      cfg_commit = 1'b1;
      cfg_we     = 1'b1;
      cfg_addr   = 4'd8;
      cfg_wdata  = 16'd2;
      step();
      cfg_commit = 1'b0;
      cfg_we     = 1'b0;
      chk_pos("wrap_apply", 0, 0);
      chk("wrap_pending_kept", 32'(pend_a), 32'd1);
      adv(2);
      chk("wrap_old_shadow_hs", 32'(hs_a), 32'd1);
      chk("wrap_old_shadow_vs", 32'(vs_a), 32'd0);
      adv(125);
      chk_pos("reapply_at", 15, 7);
      chk("reapply_pending", 32'(pend_a), 32'd1);
      step();
      chk("reapply_cleared", 32'(pend_a), 32'd0);
      adv(2);
      chk("reapply_hs", 32'(hs_a), 32'd0);
      chk("reapply_vs", 32'(vs_a), 32'd1);

      // One-cycle reset mid-frame with a commit pending.
      wr(4'd0, 16'd4);
      commit();
      adv(49);
      chk_pos("pre_reset", 5, 3);
      chk("pre_reset_de", 32'(de_a), 32'd1);
      chk("pre_reset_vs", 32'(vs_a), 32'd1);
      chk("pre_reset_pending", 32'(pend_a), 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk_pos("reset", 0, 0);
      chk("reset_pending", 32'(pend_a), 32'd0);
      chk("reset_de", 32'(de_a), 32'd0);
      chk("reset_pix", 32'(pout_a), 32'd0);
      chk("reset_fs", 32'(fs_a), 32'd0);
      chk("reset_ls", 32'(ls_a), 32'd0);
      chk("reset_hs", 32'(hs_a), 32'd0);
      chk("reset_vs", 32'(vs_a), 32'd0);
      adv(16);
      chk_pos("reset_line", 0, 1);
      adv(111);
      chk_pos("reset_frame_end", 15, 7);
      step();
      chk_pos("reset_wrap", 0, 0);
      chk("reset_no_apply", 32'(pend_a), 32'd0);
      adv(5);
      chk("reset_default_hvis", 32'(av_a), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
